// File: rtl/adder_arbiter.sv
// rtl/adder_arbiter.sv - two-port arbiter for one shared registered add/sub unit; ADDER_ARB_RR_EN selects round-robin
module adder_arbiter #(
  parameter int DATAWIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [DATAWIDTH-1:0] req0_a,
  input  logic [DATAWIDTH-1:0] req0_b,
  input  logic                 req0_sub,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [DATAWIDTH-1:0] req1_a,
  input  logic [DATAWIDTH-1:0] req1_b,
  input  logic                 req1_sub,
  output logic                 resp0_valid,
  input  logic                 resp0_ready,
  output logic                 resp1_valid,
  input  logic                 resp1_ready,
  output logic [DATAWIDTH-1:0] result,
  output logic                 grant_id
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t               state;
  state_t               state_next;
  logic                 gnt;
  logic                 any_valid;
  logic                 accept;
  logic [DATAWIDTH-1:0] op_a;
  logic [DATAWIDTH-1:0] op_b;
  logic                 op_sub;
  logic [DATAWIDTH-1:0] sum;

  assign any_valid = req0_valid | req1_valid;

`ifdef ADDER_ARB_RR_EN
  logic ptr;

  // contention goes to the preferred port; a lone requester always wins
  always_comb begin
    gnt = req1_valid;
    if (req0_valid && req1_valid) gnt = ptr;
  end

  // after every accept the preference passes to the other port
  always_ff @(posedge clk) begin
    if (rst)         ptr <= 1'b0;
    else if (accept) ptr <= ~gnt;
  end
`else
  // fixed priority: the EXU port wins whenever it is requesting
  always_comb begin
    gnt = req1_valid;
  end
`endif

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // next state and request handshake; readies never see resp_ready or operands
  always_comb begin
    state_next = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        req0_ready = req0_valid & ~gnt;
        req1_ready = req1_valid & gnt;
        accept     = any_valid;
        if (any_valid) state_next = HOLD;
      end
      HOLD: begin
        if (grant_id ? resp1_ready : resp0_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // operand mux feeding the single adder; subtract is a + ~b + 1
  assign op_a   = gnt ? req1_a   : req0_a;
  assign op_b   = gnt ? req1_b   : req0_b;
  assign op_sub = gnt ? req1_sub : req0_sub;
  assign sum    = op_a + (op_sub ? ~op_b : op_b) + DATAWIDTH'(op_sub);

  // capture result and owner on accept; held untouched through HOLD
  always_ff @(posedge clk) begin
    if (rst) begin
      result   <= '0;
      grant_id <= 1'b0;
    end else if (accept) begin
      result   <= sum;
      grant_id <= gnt;
    end
  end

  assign resp0_valid = (state == HOLD) & ~grant_id;
  assign resp1_valid = (state == HOLD) &  grant_id;

endmodule

// File: tb/tb_adder_arbiter.sv
// tb/tb_adder_arbiter.sv - self-checking bench for adder_arbiter with randomized reference-model run
module tb_adder_arbiter;
  localparam int W = 32;
`ifdef ADDER_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic         req0_sub = 1'b0, req1_sub = 1'b0;
  logic         resp0_valid, resp1_valid;
  logic         resp0_ready = 1'b0, resp1_ready = 1'b0;
  logic [W-1:0] result;
  logic         grant_id;

  int n_cmp = 0;
  int n_bad = 0;

  adder_arbiter #(.DATAWIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .result(result), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] rnd();
    case ($urandom_range(0, 3))
      0:       return '1;
      1:       return '0;
      default: return W'($urandom);
    endcase
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    resp0_ready = 1'b0; resp1_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (resp0_valid !== 1'b0) begin n_bad++; $display("FAIL reset_resp0_valid got %b want 0", resp0_valid); end
    n_cmp++; if (resp1_valid !== 1'b0) begin n_bad++; $display("FAIL reset_resp1_valid got %b want 0", resp1_valid); end
    n_cmp++; if (result !== '0) begin n_bad++; $display("FAIL reset_result got %h want 0", result); end
    n_cmp++; if (grant_id !== 1'b0) begin n_bad++; $display("FAIL reset_grant_id got %b want 0", grant_id); end
    n_cmp++; if ({req0_ready, req1_ready} !== 2'b00) begin n_bad++; $display("FAIL reset_ready got %b want 00", {req0_ready, req1_ready}); end
  endtask

  task automatic test_single_op();
    do_reset();
    req1_valid = 1'b1; req1_a = 5; req1_b = 7; req1_sub = 1'b0;
    #1;
    n_cmp++; if (req1_ready !== 1'b1) begin n_bad++; $display("FAIL single_req1_ready got %b want 1", req1_ready); end
    next_cycle();
    req1_valid = 1'b0;
    #1;
    n_cmp++; if (resp1_valid !== 1'b1) begin n_bad++; $display("FAIL single_resp1_valid got %b want 1", resp1_valid); end
    n_cmp++; if (result !== 32'd12) begin n_bad++; $display("FAIL single_result got %0d want 12", result); end
    n_cmp++; if (grant_id !== 1'b1) begin n_bad++; $display("FAIL single_grant_id got %b want 1", grant_id); end
    n_cmp++; if (resp0_valid !== 1'b0) begin n_bad++; $display("FAIL single_resp0_valid got %b want 0", resp0_valid); end
    resp1_ready = 1'b1;
    next_cycle();
    resp1_ready = 1'b0;
    #1;
    n_cmp++; if (resp1_valid !== 1'b0) begin n_bad++; $display("FAIL single_consumed got %b want 0", resp1_valid); end
  endtask

  task automatic test_sub_wrap();
    logic [W-1:0] ta [2] = '{32'h0, 32'hFFFF_FFFF};
    logic         ts [2] = '{1'b1, 1'b0};
    logic [W-1:0] te [2] = '{32'hFFFF_FFFF, 32'h0};
    do_reset();
    for (int i = 0; i < 2; i++) begin
      req0_valid = 1'b1; req0_a = ta[i]; req0_b = 1; req0_sub = ts[i];
      resp0_ready = 1'b0;
      #1;
      n_cmp++; if (req0_ready !== 1'b1) begin n_bad++; $display("FAIL wrap%0d_req0_ready got %b want 1", i, req0_ready); end
      next_cycle();
      req0_valid = 1'b0;
      #1;
      n_cmp++; if (result !== te[i] || resp0_valid !== 1'b1) begin n_bad++; $display("FAIL wrap%0d_result got %h/%b want %h/1", i, result, resp0_valid, te[i]); end
      resp0_ready = 1'b1;
      next_cycle();
    end
    resp0_ready = 1'b0;
  endtask

  task automatic test_contention();
    logic exp;
    do_reset();
    req0_valid = 1'b1; req0_a = 0; req0_b = 4; req0_sub = 1'b0;
    req1_valid = 1'b1; req1_a = 0; req1_b = 8; req1_sub = 1'b0;
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) begin
      exp = RR ? 1'(i % 2) : 1'b1;
      n_cmp++; if ({req1_ready, req0_ready} !== {exp, ~exp}) begin n_bad++; $display("FAIL contend%0d_ready got %b want %b", i, {req1_ready, req0_ready}, {exp, ~exp}); end
      next_cycle();
      #1;
      n_cmp++; if (grant_id !== exp || result !== (exp ? 32'd8 : 32'd4)) begin n_bad++; $display("FAIL contend%0d_grant got %b/%0d want %b/%0d", i, grant_id, result, exp, exp ? 8 : 4); end
      next_cycle();
      #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    resp0_ready = 1'b0; resp1_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    req0_valid = 1'b1; req0_a = 10; req0_b = 3; req0_sub = 1'b1;
    next_cycle();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 1; req1_b = 2; req1_sub = 1'b0;
    resp1_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++; if (resp0_valid !== 1'b1 || result !== 32'd7) begin n_bad++; $display("FAIL bp%0d_hold got %b/%0d want 1/7", i, resp0_valid, result); end
      n_cmp++; if (req1_ready !== 1'b0 || resp1_valid !== 1'b0) begin n_bad++; $display("FAIL bp%0d_blocked got %b/%b want 0/0", i, req1_ready, resp1_valid); end
      next_cycle();
    end
    resp0_ready = 1'b1;
    next_cycle();
    resp0_ready = 1'b0;
    #1;
    n_cmp++; if (resp0_valid !== 1'b0 || req1_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release got %b/%b want 0/1", resp0_valid, req1_ready); end
    next_cycle();
    req1_valid = 1'b0;
    #1;
    n_cmp++; if (resp1_valid !== 1'b1 || result !== 32'd3 || grant_id !== 1'b1) begin n_bad++; $display("FAIL bp_req1 got %b/%0d/%b want 1/3/1", resp1_valid, result, grant_id); end
    next_cycle();
    resp1_ready = 1'b0;
  endtask

  task automatic test_reset_hold();
    do_reset();
    req1_valid = 1'b1; req1_a = 100; req1_b = 1; req1_sub = 1'b0;
    next_cycle();
    req1_valid = 1'b0;
    #1;
    n_cmp++; if (resp1_valid !== 1'b1) begin n_bad++; $display("FAIL rsthold_pre got %b want 1", resp1_valid); end
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    #1;
    n_cmp++; if (resp1_valid !== 1'b0 || result !== '0 || grant_id !== 1'b0) begin n_bad++; $display("FAIL rsthold_clear got %b/%h/%b want 0/0/0", resp1_valid, result, grant_id); end
    req0_valid = 1'b1; req0_a = 2; req0_b = 2; req0_sub = 1'b0;
    #1;
    n_cmp++; if (req0_ready !== 1'b1) begin n_bad++; $display("FAIL rsthold_accept got %b want 1", req0_ready); end
    next_cycle();
    req0_valid = 1'b0;
    #1;
    n_cmp++; if (resp0_valid !== 1'b1 || result !== 32'd4) begin n_bad++; $display("FAIL rsthold_after got %b/%0d want 1/4", resp0_valid, result); end
    resp0_ready = 1'b1;
    next_cycle();
    resp0_ready = 1'b0;
  endtask

  task automatic test_random();
    logic         busy = 1'b0;
    logic         owner = 1'b0;
    logic         ptr = 1'b0;
    logic [W-1:0] exp_res = '0;
    logic         acc0 = 1'b0, acc1 = 1'b0;
    logic         g, e0, e1;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (acc0) req0_valid = 1'b0;
      if (acc1) req1_valid = 1'b0;
      acc0 = 1'b0; acc1 = 1'b0;
      if (!req0_valid && $urandom_range(0, 1) == 1) begin
        req0_valid = 1'b1; req0_a = rnd(); req0_b = rnd(); req0_sub = 1'($urandom_range(0, 1));
      end
      if (!req1_valid && $urandom_range(0, 1) == 1) begin
        req1_valid = 1'b1; req1_a = rnd(); req1_b = rnd(); req1_sub = 1'($urandom_range(0, 1));
      end
      resp0_ready = ($urandom_range(0, 2) != 0);
      resp1_ready = ($urandom_range(0, 2) != 0);
      #1;
      e0 = 1'b0; e1 = 1'b0; g = 1'b0;
      if (!busy && (req0_valid || req1_valid)) begin
        if (req0_valid && req1_valid) g = RR ? ptr : 1'b1;
        else                          g = req1_valid;
        e0 = ~g; e1 = g;
      end
      n_cmp++; if ({req1_ready, req0_ready} !== {e1, e0}) begin n_bad++; $display("FAIL rand%0d_ready got %b want %b", i, {req1_ready, req0_ready}, {e1, e0}); end
      n_cmp++; if ({resp1_valid, resp0_valid} !== {busy & owner, busy & ~owner}) begin n_bad++; $display("FAIL rand%0d_resp_valid got %b want %b", i, {resp1_valid, resp0_valid}, {busy & owner, busy & ~owner}); end
      if (busy) begin
        n_cmp++; if (result !== exp_res || grant_id !== owner) begin n_bad++; $display("FAIL rand%0d_result got %h/%b want %h/%b", i, result, grant_id, exp_res, owner); end
      end
      if (e0 || e1) begin
        busy = 1'b1; owner = g; ptr = ~g;
        if (g) begin exp_res = req1_sub ? req1_a - req1_b : req1_a + req1_b; acc1 = 1'b1; end
        else   begin exp_res = req0_sub ? req0_a - req0_b : req0_a + req0_b; acc0 = 1'b1; end
      end else if (busy && (owner ? resp1_ready : resp0_ready)) begin
        busy = 1'b0;
      end
      next_cycle();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    resp0_ready = 1'b0; resp1_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_sub_wrap();
    test_contention();
    test_backpressure();
    test_reset_hold();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
